// File: rtl/sfr_fifo_resp_pkg.sv
// sfr_fifo_resp_pkg: shared address map, register bit positions and FSM encoding for sfr_fifo_resp
package sfr_fifo_resp_pkg;
  localparam int ADDR_W = 7;
  localparam int DATA_W = 8;
  localparam int CNT_W = 4;
  localparam logic [6:0] DAT_ADDR_D = 7'h50;
  localparam logic [6:0] STA_ADDR_D = 7'h51;
  localparam logic [6:0] CTL_ADDR_D = 7'h52;
  localparam logic [6:0] SCR_ADDR_D = 7'h53;
  localparam logic [6:0] PEEK_ADDR = 7'h54;
  localparam int STA_UDF = 0;
  localparam int STA_OVF = 1;
  localparam int STA_EMPTY = 2;
  localparam int STA_FULL = 3;
  localparam int CTL_FLUSH = 0;
  localparam int CTL_IRQ_EN = 1;
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK, ST_HOLD} state_t;
endpackage

// File: rtl/sfr_fifo_resp_if.sv
// sfr_fifo_resp_if: SFR bus between the MCU decode (master) and the FIFO responder (slave)
interface sfr_fifo_resp_if;
  import sfr_fifo_resp_pkg::*;
  logic              sfr_r;
  logic              sfr_w;
  logic [ADDR_W-1:0] sfr_addr;
  logic [DATA_W-1:0] sfr_wdat;
  logic              sfr_ack;
  logic [DATA_W-1:0] sfr_rdat;
  logic              irq;
  modport master (output sfr_r, sfr_w, sfr_addr, sfr_wdat, input sfr_ack, sfr_rdat, irq);
  modport slave (input sfr_r, sfr_w, sfr_addr, sfr_wdat, output sfr_ack, sfr_rdat, irq);
endinterface

// File: rtl/sfr_byte_fifo.sv
// sfr_byte_fifo: DEPTH-entry byte FIFO; push on full and pop on empty are ignored, flush empties it
module sfr_byte_fifo
  import sfr_fifo_resp_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic             i_flush,
  input  logic [7:0]       i_wdat,
  output logic [7:0]       o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_cnt
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0]       r_mem [DEPTH];
  logic [AW-1:0]    r_wp, r_rp;
  logic [CNT_W-1:0] r_cnt;
  logic             w_push, w_pop;
  assign o_full = r_cnt == CNT_W'(DEPTH);
  assign o_empty = r_cnt == '0;
  assign o_cnt = r_cnt;
  assign o_head = r_mem[r_rp];
  assign w_push = i_push & ~o_full;
  assign w_pop = i_pop & ~o_empty;
  // storage array, written only on an accepted push
  always_ff @(posedge clk) if (w_push) r_mem[r_wp] <= i_wdat;
  // pointers wrap modulo DEPTH; flush shares the reset path
  always_ff @(posedge clk) begin
    if (srst || i_flush) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      r_wp <= w_push ? r_wp + 1'b1 : r_wp;
      r_rp <= w_pop ? r_rp + 1'b1 : r_rp;
      r_cnt <= r_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end
endmodule

// File: rtl/sfr_fifo_resp.sv
// sfr_fifo_resp: SFR responder mapping a byte FIFO, status, control and scratch registers; SFR_FIFO_RESP_PEEK_EN adds a non-popping head read at 7'h54
module sfr_fifo_resp
  import sfr_fifo_resp_pkg::*;
#(
  parameter int         DEPTH    = 8,
  parameter int         WAIT_CYC = 0,
  parameter logic [6:0] DAT_ADDR = DAT_ADDR_D,
  parameter logic [6:0] STA_ADDR = STA_ADDR_D,
  parameter logic [6:0] CTL_ADDR = CTL_ADDR_D,
  parameter logic [6:0] SCR_ADDR = SCR_ADDR_D
) (
  input logic            clk,
  input logic            srst,
  sfr_fifo_resp_if.slave bus
);
  state_t           r_st, w_st_nxt;
  logic [1:0]       r_wcnt;
  logic             r_ovf, r_udf, r_ie, r_ack, r_irq;
  logic [7:0]       r_scr, r_rdat, w_head, w_rmux, w_sta, w_ctl;
  logic [CNT_W-1:0] w_cnt;
  logic             w_full, w_empty, w_acc, w_wr, w_rd, w_push, w_pop, w_flush;
  assign w_acc = r_st == ST_ACK;
  assign w_wr = w_acc & bus.sfr_w;
  assign w_rd = w_acc & bus.sfr_r & ~bus.sfr_w;
  assign w_push = w_wr & (bus.sfr_addr == DAT_ADDR);
  assign w_pop = w_rd & (bus.sfr_addr == DAT_ADDR);
  assign w_flush = w_wr & (bus.sfr_addr == CTL_ADDR) & bus.sfr_wdat[CTL_FLUSH];
  assign w_sta = {w_cnt, w_full, w_empty, r_ovf, r_udf};
  assign w_ctl = {6'b0, r_ie, 1'b0};
  assign bus.sfr_ack = r_ack;
  assign bus.sfr_rdat = r_rdat;
  assign bus.irq = r_irq;
  sfr_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .srst    (srst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_wdat  (bus.sfr_wdat),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_cnt   (w_cnt)
  );
  // read data selected from the addressed register; empty FIFO and unmapped addresses read 0
  always_comb begin
    w_rmux = bus.sfr_addr == DAT_ADDR ? (w_empty ? 8'h00 : w_head) :
             bus.sfr_addr == STA_ADDR ? w_sta :
             bus.sfr_addr == CTL_ADDR ? w_ctl :
             bus.sfr_addr == SCR_ADDR ? r_scr : 8'h00;
`ifdef SFR_FIFO_RESP_PEEK_EN
    if (bus.sfr_addr == PEEK_ADDR) w_rmux = w_empty ? 8'h00 : w_head;
`endif
  end
  // FSM state register
  always_ff @(posedge clk) r_st <= srst ? ST_IDLE : w_st_nxt;
  // FSM next state: HOLD swallows the cycle in which the master is still dropping its request
  always_comb begin
    w_st_nxt = r_st;
    case (r_st)
      ST_IDLE: w_st_nxt = (bus.sfr_r | bus.sfr_w) ? (WAIT_CYC > 0 ? ST_WAIT : ST_ACK) : ST_IDLE;
      ST_WAIT: w_st_nxt = r_wcnt == 2'(WAIT_CYC - 1) ? ST_ACK : ST_WAIT;
      ST_ACK:  w_st_nxt = ST_HOLD;
      default: w_st_nxt = ST_IDLE;
    endcase
  end
  // wait-state counter, restarts every time WAIT is entered
  always_ff @(posedge clk) r_wcnt <= (srst || r_st != ST_WAIT) ? 2'd0 : r_wcnt + 2'd1;
  // registered ack, read data and interrupt
  always_ff @(posedge clk) begin
    if (srst) begin
      r_ack <= 1'b0;
      r_rdat <= 8'h00;
      r_irq <= 1'b0;
    end else begin
      r_ack <= w_acc;
      r_rdat <= w_rd ? w_rmux : 8'h00;
      r_irq <= r_ie & ~w_empty;
    end
  end
  // sticky flags, control and scratch registers, all updated on the edge ending ACK
  always_ff @(posedge clk) begin
    if (srst) begin
      r_ovf <= 1'b0;
      r_udf <= 1'b0;
      r_ie <= 1'b0;
      r_scr <= 8'h00;
    end else begin
      if (w_push & w_full) r_ovf <= 1'b1;
      else if (w_wr & (bus.sfr_addr == STA_ADDR) & bus.sfr_wdat[STA_OVF]) r_ovf <= 1'b0;
      if (w_pop & w_empty) r_udf <= 1'b1;
      else if (w_wr & (bus.sfr_addr == STA_ADDR) & bus.sfr_wdat[STA_UDF]) r_udf <= 1'b0;
      if (w_wr & (bus.sfr_addr == CTL_ADDR)) r_ie <= bus.sfr_wdat[CTL_IRQ_EN];
      if (w_wr & (bus.sfr_addr == SCR_ADDR)) r_scr <= bus.sfr_wdat;
    end
  end
endmodule

// File: tb/tb_sfr_fifo_resp.sv
// tb_sfr_fifo_resp: randomized and directed checks of sfr_fifo_resp against a queue-based model (SFR_FIFO_RESP_PEEK_EN aware)
module tb_sfr_fifo_resp;
  logic clk = 1'b0;
  logic srst, srst3;
  int cyc = 0, checks = 0, errors = 0;
  sfr_fifo_resp_if b0();
  sfr_fifo_resp_if b3();
  sfr_fifo_resp #(.DEPTH(8), .WAIT_CYC(0)) dut (.clk(clk), .srst(srst), .bus(b0));
  sfr_fifo_resp #(.DEPTH(8), .WAIT_CYC(3)) dut3 (.clk(clk), .srst(srst3), .bus(b3));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  logic [7:0] q[$];
  bit m_ovf, m_udf, m_ie, chk_en, exp_rd, irq_old, irq_new;
  logic [7:0] m_scr, exp_rdat;
  int exp_ack_cyc = -10, irq_chg = 0;
  task automatic chk(input string n, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at cycle %0d", n, got, exp, cyc);
    end
  endtask
  function automatic logic [7:0] m_read(input logic [6:0] a);
    logic [3:0] n = 4'(q.size());
    case (a)
      7'h50: return q.size() != 0 ? q[0] : 8'h00;
      7'h51: return {n, q.size() == 8, q.size() == 0, m_ovf, m_udf};
      7'h52: return {6'b0, m_ie, 1'b0};
      7'h53: return m_scr;
`ifdef SFR_FIFO_RESP_PEEK_EN
      7'h54: return q.size() != 0 ? q[0] : 8'h00;
`endif
      default: return 8'h00;
    endcase
  endfunction
  function automatic void m_apply(input bit r, input bit w, input logic [6:0] a, input logic [7:0] d);
    if (w) begin
      case (a)
        7'h50: if (q.size() < 8) q.push_back(d); else m_ovf = 1'b1;
        7'h51: begin if (d[1]) m_ovf = 1'b0; if (d[0]) m_udf = 1'b0; end
        7'h52: begin if (d[0]) q.delete(); m_ie = d[1]; end
        7'h53: m_scr = d;
        default: ;
      endcase
    end else if (r && a == 7'h50) begin
      if (q.size() != 0) void'(q.pop_front()); else m_udf = 1'b1;
    end
  endfunction
  always @(negedge clk) begin
    if (chk_en) begin
      if (cyc == exp_ack_cyc) begin
        chk("ack", {7'b0, b0.sfr_ack}, 8'h01);
        if (exp_rd) chk("rdat", b0.sfr_rdat, exp_rdat);
      end else begin
        chk("ack_idle", {7'b0, b0.sfr_ack}, 8'h00);
        chk("rdat_idle", b0.sfr_rdat, 8'h00);
      end
      chk("irq", {7'b0, b0.irq}, {7'b0, (cyc >= irq_chg) ? irq_new : irq_old});
    end
  end
  task automatic acc(input bit r, input bit w, input logic [6:0] a, input logic [7:0] d,
                     input bit hold, output logic [7:0] got, output int lat);
    bit cur;
    exp_rdat = m_read(a);
    exp_rd = r & ~w;
    exp_ack_cyc = cyc + 2;
    b0.sfr_r = r; b0.sfr_w = w; b0.sfr_addr = a; b0.sfr_wdat = d;
    got = 8'h00;
    lat = -1;
    for (int n = 1; n <= 8 && lat < 0; n++) begin
      @(negedge clk);
      if (b0.sfr_ack) begin lat = n; got = b0.sfr_rdat; end
    end
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL ack_timeout: no ack within 8 cycles for addr %02h", a);
    end
    cur = (cyc >= irq_chg) ? irq_new : irq_old;
    m_apply(r, w, a, d);
    irq_old = cur;
    irq_new = m_ie && q.size() != 0;
    irq_chg = cyc + 1;
    if (hold) @(negedge clk);
    b0.sfr_r = 1'b0; b0.sfr_w = 1'b0;
    @(negedge clk);
  endtask
  task automatic wr(input logic [6:0] a, input logic [7:0] d);
    logic [7:0] g; int l;
    acc(1'b0, 1'b1, a, d, 1'b0, g, l);
  endtask
  task automatic rd(input logic [6:0] a, output logic [7:0] g);
    int l;
    acc(1'b1, 1'b0, a, 8'h00, 1'b0, g, l);
  endtask
  task automatic acc3(input bit w, input logic [6:0] a, input logic [7:0] d, output logic [7:0] got, output int lat);
    b3.sfr_r = ~w; b3.sfr_w = w; b3.sfr_addr = a; b3.sfr_wdat = d;
    got = 8'h00;
    lat = -1;
    for (int n = 1; n <= 12 && lat < 0; n++) begin
      @(negedge clk);
      if (b3.sfr_ack) begin lat = n; got = b3.sfr_rdat; end
    end
    if (lat < 0) begin
      checks++; errors++;
      $display("FAIL ack3_timeout: no ack within 12 cycles for addr %02h", a);
    end
    b3.sfr_r = 1'b0; b3.sfr_w = 1'b0;
    @(negedge clk);
    chk("ack3_single", {7'b0, b3.sfr_ack}, 8'h00);
    @(negedge clk);
  endtask
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [7:0] g, d;
    logic [6:0] a;
    int l, op;
    bit r, w, seen;
    b0.sfr_r = 0; b0.sfr_w = 0; b0.sfr_addr = 0; b0.sfr_wdat = 0;
    b3.sfr_r = 0; b3.sfr_w = 0; b3.sfr_addr = 0; b3.sfr_wdat = 0;
    chk_en = 0; srst = 1; srst3 = 1;
    repeat (3) @(negedge clk);
    srst = 0; srst3 = 0;
    q.delete(); m_ovf = 0; m_udf = 0; m_ie = 0; m_scr = 8'h00;
    irq_old = 0; irq_new = 0; irq_chg = 0;
    chk_en = 1;
    rd(7'h51, g); chk("sta_reset", g, 8'h04);
    rd(7'h53, g); chk("scr_reset", g, 8'h00);
    chk("irq_reset", {7'b0, b0.irq}, 8'h00);
    acc(1'b0, 1'b1, 7'h53, 8'hA5, 1'b1, g, l);
    chk("ack_latency", 8'(l), 8'd2);
    rd(7'h53, g); chk("scr_rb", g, 8'hA5);
    for (int i = 0; i < 8; i++) wr(7'h50, 8'h11 + 8'(i));
    rd(7'h51, g); chk("sta_full", g, 8'h88);
    wr(7'h50, 8'hFF);
    rd(7'h51, g); chk("sta_ovf", g, 8'h8A);
    for (int i = 0; i < 8; i++) begin rd(7'h50, g); chk("pop_order", g, 8'h11 + 8'(i)); end
    rd(7'h51, g); chk("sta_drained", g, 8'h06);
    wr(7'h51, 8'h02);
    rd(7'h51, g); chk("sta_ovf_clr", g, 8'h04);
    rd(7'h50, g); chk("pop_empty", g, 8'h00);
    rd(7'h51, g); chk("sta_udf", g, 8'h05);
    wr(7'h51, 8'h03);
    rd(7'h51, g); chk("sta_w1c", g, 8'h04);
    wr(7'h52, 8'h02);
    wr(7'h50, 8'h3C);
    chk("irq_on", {7'b0, b0.irq}, 8'h01);
    rd(7'h50, g); chk("pop_3c", g, 8'h3C);
    chk("irq_off", {7'b0, b0.irq}, 8'h00);
    for (int i = 0; i < 3; i++) wr(7'h50, 8'(i));
    wr(7'h52, 8'h01);
    rd(7'h51, g); chk("sta_flush", g, 8'h04);
    rd(7'h52, g); chk("ctl_rd", g, 8'h00);
`ifdef SFR_FIFO_RESP_PEEK_EN
    wr(7'h50, 8'h5A);
    rd(7'h54, g); chk("peek1", g, 8'h5A);
    rd(7'h54, g); chk("peek2", g, 8'h5A);
    rd(7'h51, g); chk("peek_cnt", g, 8'h10);
    rd(7'h50, g);
`else
    rd(7'h54, g); chk("unmapped_54", g, 8'h00);
`endif
    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 9);
      d = 8'($urandom);
      r = 0; w = 0;
      case (op)
        0, 1, 2: begin a = 7'h50; w = 1; end
        3, 4:    begin a = 7'h50; r = 1; end
        5:       begin a = 7'h51; r = 1; end
        6:       begin a = 7'h51; w = 1; end
        7:       begin a = 7'h52; w = $urandom_range(0, 1) == 1; r = ~w; if (d[0]) d[0] = $urandom_range(0, 3) == 0; end
        8:       begin a = 7'h53; w = $urandom_range(0, 1) == 1; r = ~w; end
        default: begin
          a = $urandom_range(0, 1) == 1 ? 7'($urandom_range(7'h50, 7'h54)) : 7'($urandom);
          op = $urandom_range(1, 3);
          r = op[0]; w = op[1];
        end
      endcase
      acc(r, w, a, d, $urandom_range(0, 3) == 0, g, l);
    end
    acc3(1'b1, 7'h53, 8'h77, g, l); chk("ack3_latency_w", 8'(l), 8'd5);
    acc3(1'b0, 7'h53, 8'h00, g, l); chk("ack3_latency_r", 8'(l), 8'd5);
    chk("scr3_rb", g, 8'h77);
    b3.sfr_w = 1; b3.sfr_addr = 7'h53; b3.sfr_wdat = 8'h99;
    repeat (2) @(negedge clk);
    srst3 = 1;
    @(negedge clk);
    srst3 = 0; b3.sfr_w = 0;
    seen = 0;
    repeat (8) begin @(negedge clk); if (b3.sfr_ack) seen = 1; end
    chk("ack3_after_rst", {7'b0, seen}, 8'h00);
    acc3(1'b0, 7'h53, 8'h00, g, l);
    chk("ack3_idle_latency", 8'(l), 8'd5);
    chk("scr3_reset", g, 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
